// File: rtl/locker_supervisor.sv
// Front-end supervisor for the locker's code-entry FSM: press pulses,
// open hold, failure counting, lockout and stale-entry abort.
module locker_supervisor #(
  parameter int MAX_FAIL    = 3,
  parameter int OPEN_CYCLES = 50000000,
  parameter int LOCK_CYCLES = 500000000,
  parameter int IDLE_CYCLES = 250000000,
  parameter int CNT_W       = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] BTN_IN,
  input  logic       FSM_SUCCESS,
  input  logic       FSM_WRONG,
  output logic [5:0] BTN_OUT,
  output logic       FSM_RST,
  output logic       UNLOCK,
  output logic       LOCKED_OUT,
  output logic [3:0] FAIL_CNT,
  output logic [2:0] DIGITS
);

  localparam logic [1:0] S_ENTRY = 2'd0;
  localparam logic [1:0] S_OPEN  = 2'd1;
  localparam logic [1:0] S_LOCK  = 2'd2;

  localparam logic [CNT_W-1:0] OPEN_LD = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [3:0]       FAIL_MAX = 4'(MAX_FAIL);

  logic [1:0]       state;
  logic [5:0]       btn_prev;
  logic             succ_prev;
  logic             wrong_prev;
  logic [CNT_W-1:0] cnt;

  logic [5:0] rise;
  logic [5:0] pick;
  logic       succ_ev;
  logic       wrong_ev;
  logic       fwd;
  logic       cnt_zero;
  logic [3:0] fail_nxt;

  // Two's-complement trick isolates the lowest set rise bit.
  always_comb begin
    rise     = BTN_IN & ~btn_prev;
    pick     = rise & (~rise + 6'd1);
    succ_ev  = FSM_SUCCESS & ~succ_prev;
    wrong_ev = FSM_WRONG & ~wrong_prev;
    fwd      = (state == S_ENTRY) && !FSM_RST &&
               !succ_ev && !wrong_ev && (rise != 6'd0);
    cnt_zero = (cnt == '0);
    fail_nxt = FAIL_CNT + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_ENTRY;
      btn_prev   <= BTN_IN;
      succ_prev  <= 1'b0;
      wrong_prev <= 1'b0;
      cnt        <= '0;
      BTN_OUT    <= 6'd0;
      FSM_RST    <= 1'b1;
      UNLOCK     <= 1'b0;
      LOCKED_OUT <= 1'b0;
      FAIL_CNT   <= 4'd0;
      DIGITS     <= 3'd0;
    end else begin
      btn_prev   <= BTN_IN;
      succ_prev  <= FSM_SUCCESS;
      wrong_prev <= FSM_WRONG;
      BTN_OUT    <= 6'd0;
      FSM_RST    <= 1'b0;
      case (state)
        S_ENTRY: begin
          if (succ_ev) begin
            FAIL_CNT <= 4'd0;
            DIGITS   <= 3'd0;
            FSM_RST  <= 1'b1;
            cnt      <= OPEN_LD;
            UNLOCK   <= 1'b1;
            state    <= S_OPEN;
          end else if (wrong_ev) begin
            FAIL_CNT <= fail_nxt;
            DIGITS   <= 3'd0;
            FSM_RST  <= 1'b1;
            if (fail_nxt == FAIL_MAX) begin
              cnt        <= LOCK_LD;
              LOCKED_OUT <= 1'b1;
              state      <= S_LOCK;
            end
          end else if (fwd) begin
            BTN_OUT <= pick;
            cnt     <= IDLE_LD;
            if (DIGITS != 3'd6) begin
              DIGITS <= DIGITS + 3'd1;
            end
          end else if (DIGITS != 3'd0) begin
            if (cnt_zero) begin
              FSM_RST <= 1'b1;
              DIGITS  <= 3'd0;
            end else begin
              cnt <= cnt - ONE;
            end
          end
        end
        S_OPEN: begin
          if (cnt_zero) begin
            UNLOCK <= 1'b0;
            state  <= S_ENTRY;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        S_LOCK: begin
          if (cnt_zero) begin
            LOCKED_OUT <= 1'b0;
            FAIL_CNT   <= 4'd0;
            FSM_RST    <= 1'b1;
            state      <= S_ENTRY;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= S_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_locker_supervisor.sv
// Scoreboard bench for locker_supervisor with a behavioural entry FSM
// expecting the code A,B,C,D,E,F.
module tb_locker_supervisor;

  localparam int K_BTN = 0;
  localparam int K_RST = 1;
  localparam int K_UNL = 2;
  localparam int K_LCK = 3;

  localparam logic [17:0] GOOD = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [17:0] BAD  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] BTN_IN = 6'b000001;
  logic       FSM_SUCCESS;
  logic       FSM_WRONG;
  logic [5:0] BTN_OUT;
  logic       FSM_RST;
  logic       UNLOCK;
  logic       LOCKED_OUT;
  logic [3:0] FAIL_CNT;
  logic [2:0] DIGITS;

  locker_supervisor #(
    .MAX_FAIL(3),
    .OPEN_CYCLES(8),
    .LOCK_CYCLES(16),
    .IDLE_CYCLES(20),
    .CNT_W(32)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .BTN_IN(BTN_IN),
    .FSM_SUCCESS(FSM_SUCCESS),
    .FSM_WRONG(FSM_WRONG),
    .BTN_OUT(BTN_OUT),
    .FSM_RST(FSM_RST),
    .UNLOCK(UNLOCK),
    .LOCKED_OUT(LOCKED_OUT),
    .FAIL_CNT(FAIL_CNT),
    .DIGITS(DIGITS)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Entry FSM model: six digits, then a sticky success or wrong flag.
  int         m_idx = 0;
  logic       m_bad = 1'b0;
  logic       m_succ = 1'b0;
  logic       m_wrong = 1'b0;
  logic [5:0] m_oh;
  assign FSM_SUCCESS = m_succ;
  assign FSM_WRONG   = m_wrong;

  always @(posedge CLK) begin
    if (FSM_RST === 1'b1) begin
      m_idx   <= 0;
      m_bad   <= 1'b0;
      m_succ  <= 1'b0;
      m_wrong <= 1'b0;
    end else if (BTN_OUT != 6'd0 && !m_succ && !m_wrong) begin
      m_oh = 6'b1 << m_idx;
      if (m_idx == 5) begin
        if (m_bad || BTN_OUT != m_oh) m_wrong <= 1'b1;
        else m_succ <= 1'b1;
      end else if (BTN_OUT != m_oh) begin
        m_bad <= 1'b1;
      end
      m_idx <= m_idx + 1;
    end
  end

  typedef struct {
    int         kind;
    logic [7:0] val;
    logic [2:0] dig;
    logic [3:0] fl;
    int         at;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  failures = 0;
  int  unl_len = 0;
  int  lck_len = 0;

  function automatic void push(int k, logic [7:0] v, logic [2:0] d,
                               logic [3:0] f, int at);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.dig  = d;
    e.fl   = f;
    e.at   = at;
    q.push_back(e);
  endfunction

  function automatic void got(int k, logic [7:0] v);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected kind=%0d val=%h dig=%0d fl=%0d cyc=%0d",
               k, v, DIGITS, FAIL_CNT, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != k || e.val !== v || e.dig !== DIGITS ||
        e.fl !== FAIL_CNT || e.at != cyc) begin
      failures++;
      $display("FAIL event got k=%0d v=%h d=%0d f=%0d c=%0d exp k=%0d v=%h d=%0d f=%0d c=%0d",
               k, v, DIGITS, FAIL_CNT, cyc,
               e.kind, e.val, e.dig, e.fl, e.at);
    end
  endfunction

  always @(negedge CLK) begin
    if (!UNLOCK && unl_len > 0) begin
      got(K_UNL, 8'(unl_len));
      unl_len = 0;
    end
    if (!LOCKED_OUT && lck_len > 0) begin
      got(K_LCK, 8'(lck_len));
      lck_len = 0;
    end
    if (UNLOCK) unl_len++;
    if (LOCKED_OUT) lck_len++;
    if (BTN_OUT != 6'd0) got(K_BTN, {2'b00, BTN_OUT});
    if (FSM_RST) got(K_RST, {UNLOCK, LOCKED_OUT, BTN_OUT});
    if (UNLOCK && LOCKED_OUT) begin
      checks++;
      failures++;
      $display("FAIL exclusive unlock=1 locked_out=1 cyc=%0d", cyc);
    end
  end

  task automatic press1(input int b, input logic [2:0] d,
                        input logic [3:0] f, output int t);
    logic [5:0] oh;
    oh = 6'b1 << b;
    @(negedge CLK);
    BTN_IN = oh;
    t = cyc;
    push(K_BTN, {2'b00, oh}, d, f, t + 1);
    @(negedge CLK);
    BTN_IN = 6'd0;
  endtask

  // outcome: 0 ok, 1 wrong, 2 lockout, 3 ok head only, 4 lockout head only
  task automatic attempt(input logic [17:0] code, input logic [3:0] f,
                         input int outcome, output int t);
    for (int i = 0; i < 6; i++) begin
      press1(int'(code[3*i +: 3]), 3'(i + 1), f, t);
      if (i == 5) begin
        case (outcome)
          0: begin
            push(K_RST, 8'h80, 3'd0, 4'd0, t + 3);
            push(K_UNL, 8'd8, 3'd0, 4'd0, t + 11);
          end
          1: push(K_RST, 8'h00, 3'd0, f + 4'd1, t + 3);
          2: begin
            push(K_RST, 8'h40, 3'd0, 4'd3, t + 3);
            push(K_LCK, 8'd16, 3'd0, 4'd0, t + 19);
            push(K_RST, 8'h00, 3'd0, 4'd0, t + 19);
          end
          3: push(K_RST, 8'h80, 3'd0, 4'd0, t + 3);
          default: push(K_RST, 8'h40, 3'd0, 4'd3, t + 3);
        endcase
      end
      repeat (2) @(negedge CLK);
    end
  endtask

  initial begin
    int t;
    push(K_RST, 8'h00, 3'd0, 4'd0, 1);
    push(K_RST, 8'h00, 3'd0, 4'd0, 2);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    BTN_IN = 6'd0;
    repeat (2) @(negedge CLK);

    attempt(GOOD, 4'd0, 0, t);
    repeat (10) @(negedge CLK);

    @(negedge CLK);
    BTN_IN = 6'b000110;
    t = cyc;
    push(K_BTN, 8'h02, 3'd1, 4'd0, t + 1);
    push(K_RST, 8'h00, 3'd0, 4'd0, t + 21);
    repeat (10) @(negedge CLK);
    BTN_IN = 6'd0;
    repeat (14) @(negedge CLK);

    attempt(BAD, 4'd0, 1, t);
    repeat (2) @(negedge CLK);
    attempt(BAD, 4'd1, 1, t);
    repeat (2) @(negedge CLK);
    attempt(BAD, 4'd2, 2, t);
    repeat (2) @(negedge CLK);
    BTN_IN = 6'b000001;
    @(negedge CLK);
    BTN_IN = 6'd0;
    repeat (3) @(negedge CLK);
    BTN_IN = 6'b100000;
    @(negedge CLK);
    BTN_IN = 6'd0;
    repeat (12) @(negedge CLK);

    attempt(BAD, 4'd0, 1, t);
    repeat (2) @(negedge CLK);
    attempt(BAD, 4'd1, 1, t);
    repeat (2) @(negedge CLK);
    attempt(GOOD, 4'd2, 0, t);
    repeat (10) @(negedge CLK);

    press1(0, 3'd1, 4'd0, t);
    repeat (2) @(negedge CLK);
    press1(1, 3'd2, 4'd0, t);
    repeat (2) @(negedge CLK);
    press1(2, 3'd3, 4'd0, t);
    push(K_RST, 8'h00, 3'd0, 4'd0, t + 21);
    repeat (25) @(negedge CLK);
    press1(0, 3'd1, 4'd0, t);
    push(K_RST, 8'h00, 3'd0, 4'd0, t + 21);
    repeat (24) @(negedge CLK);

    attempt(GOOD, 4'd0, 3, t);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    push(K_UNL, 8'd5, 3'd0, 4'd0, t + 8);
    push(K_RST, 8'h00, 3'd0, 4'd0, t + 8);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    attempt(BAD, 4'd0, 1, t);
    repeat (2) @(negedge CLK);
    attempt(BAD, 4'd1, 1, t);
    repeat (2) @(negedge CLK);
    attempt(BAD, 4'd2, 4, t);
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    push(K_LCK, 8'd10, 3'd0, 4'd0, t + 13);
    push(K_RST, 8'h00, 3'd0, 4'd0, t + 13);
    @(negedge CLK);
    RST = 1'b0;
    repeat (6) @(negedge CLK);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending events left=%0d required=0 head_at=%0d",
               q.size(), q[0].at);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
